// File: rtl/lcm_regfile.sv
// Local control module: decodes DMUX control packets into register writes and reads,
// returns 2-flit responses on the MUX bus. Define LCM_WR_ACK_EN to acknowledge writes.
module lcm_regfile #(
    parameter logic [7:0]  LMID     = 8'd3,
    parameter int unsigned NUM_CFG  = 16,
    parameter int unsigned NUM_STAT = 16,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TS_W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [133:0]                 in_data,
    input  logic                         in_data_wr,
    input  logic                         in_data_valid,
    input  logic                         in_data_valid_wr,
    output logic                         in_ready,
    output logic [133:0]                 out_data,
    output logic                         out_data_wr,
    output logic                         out_data_valid,
    output logic                         out_data_valid_wr,
    input  logic                         out_ready,
    output logic [NUM_CFG*DATA_W-1:0]    cfg_regs,
    output logic [NUM_CFG-1:0]           cfg_wr_pulse,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_regs,
    output logic [TS_W-1:0]              timestamp
);

    localparam logic [7:0] OpWr = 8'h01;
    localparam logic [7:0] OpRd = 8'h02;

    typedef enum logic [2:0] {StIdle, StRecv, StExec, StRespHead, StRespTail} state_e;

    state_e state_q, state_d;
    logic [7:0]  op_q, op_d, lmid_q, lmid_d, idx_q, idx_d;
    logic [63:0] wval_q, wval_d;
    logic [7:0]  rsp_st_q, rsp_st_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [NUM_CFG-1:0][DATA_W-1:0] cfg_q;
    logic [NUM_CFG-1:0] wr_sel, pulse_q;
    logic [TS_W-1:0] ts_q;

    logic [DATA_W-1:0] cfg_rd, stat_rd;
    logic [7:0]  cmd_op, cmd_lmid;
    logic        cmd_ok, is_head, is_cfg, is_stat, is_ts;
    logic        unused_bits;

    assign unused_bits = ^{in_data[131:128], in_data[103:64]};

    assign is_head  = in_data[133:132] == 2'b01;
    // In IDLE the decision uses the head flit itself (single-flit packet case).
    assign cmd_op   = (state_q == StIdle) ? in_data[127:120] : op_q;
    assign cmd_lmid = (state_q == StIdle) ? in_data[119:112] : lmid_q;
    assign cmd_ok   = in_data_valid && cmd_lmid == LMID && (cmd_op == OpWr || cmd_op == OpRd);

    assign is_cfg  = 32'(idx_q) < NUM_CFG;
    assign is_stat = !is_cfg && 32'(idx_q) < NUM_CFG + NUM_STAT;
    assign is_ts   = idx_q == 8'hFF;

    always_comb begin
        cfg_rd = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
            if (32'(idx_q) == i) cfg_rd = cfg_q[i];
        end
        stat_rd = '0;
        for (int unsigned i = 0; i < NUM_STAT; i++) begin
            if (32'(idx_q) == i + NUM_CFG) stat_rd = stat_regs[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lmid_d     = lmid_q;
        idx_d      = idx_q;
        wval_d     = wval_q;
        rsp_st_d   = rsp_st_q;
        rsp_data_d = rsp_data_q;
        wr_sel     = '0;
        unique case (state_q)
            StIdle: begin
                if (in_data_wr && is_head) begin
                    op_d   = in_data[127:120];
                    lmid_d = in_data[119:112];
                    idx_d  = in_data[111:104];
                    wval_d = in_data[63:0];
                    if (in_data_valid_wr) state_d = cmd_ok ? StExec : StIdle;
                    else                  state_d = StRecv;
                end
            end
            StRecv: begin
                if (in_data_valid_wr) state_d = cmd_ok ? StExec : StIdle;
            end
            StExec: begin
                if (op_q == OpWr) begin
                    rsp_data_d = 64'(wval_q[DATA_W-1:0]);
                    rsp_st_d   = is_cfg ? 8'h00 : 8'hFF;
                    for (int unsigned i = 0; i < NUM_CFG; i++) begin
                        if (32'(idx_q) == i) wr_sel[i] = 1'b1;
                    end
`ifdef LCM_WR_ACK_EN
                    state_d = StRespHead;
`else
                    state_d = StIdle;
`endif
                end else begin
                    rsp_st_d = 8'h00;
                    if (is_cfg)       rsp_data_d = 64'(cfg_rd);
                    else if (is_stat) rsp_data_d = 64'(stat_rd);
                    else if (is_ts)   rsp_data_d = 64'(ts_q);
                    else begin
                        rsp_data_d = '0;
                        rsp_st_d   = 8'hFF;
                    end
                    state_d = StRespHead;
                end
            end
            StRespHead: if (out_ready) state_d = StRespTail;
            StRespTail: if (out_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            lmid_q     <= '0;
            idx_q      <= '0;
            wval_q     <= '0;
            rsp_st_q   <= '0;
            rsp_data_q <= '0;
            cfg_q      <= '0;
            pulse_q    <= '0;
            ts_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lmid_q     <= lmid_d;
            idx_q      <= idx_d;
            wval_q     <= wval_d;
            rsp_st_q   <= rsp_st_d;
            rsp_data_q <= rsp_data_d;
            for (int unsigned i = 0; i < NUM_CFG; i++) begin
                if (wr_sel[i]) cfg_q[i] <= wval_q[DATA_W-1:0];
            end
            pulse_q    <= wr_sel;
            ts_q       <= ts_q + TS_W'(1);
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == StRespHead) begin
            out_data = {2'b01, 4'b0, op_q | 8'h80, LMID, idx_q, rsp_st_q, 96'b0};
        end else if (state_q == StRespTail) begin
            out_data = {2'b10, 68'b0, rsp_data_q};
        end
    end

    assign out_data_wr       = (state_q == StRespHead || state_q == StRespTail) && out_ready;
    assign out_data_valid    = state_q == StRespTail && out_ready;
    assign out_data_valid_wr = state_q == StRespTail && out_ready;
    assign in_ready          = state_q == StIdle || state_q == StRecv;
    assign cfg_regs          = cfg_q;
    assign cfg_wr_pulse      = pulse_q;
    assign timestamp         = ts_q;

endmodule

// File: tb/tb_lcm_regfile.sv
// Self-checking bench for lcm_regfile: vector table, latency/stall/reset sequences and
// randomized commands against an address-map reference model.
module tb_lcm_regfile;

    localparam int NC = 16;
    localparam int NS = 16;
`ifdef LCM_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic               clk = 0;
    logic               rst;
    logic [133:0]       in_data;
    logic               in_data_wr, in_data_valid, in_data_valid_wr, in_ready;
    logic [133:0]       out_data;
    logic               out_data_wr, out_data_valid, out_data_valid_wr, out_ready;
    logic [NC*64-1:0]   cfg_regs;
    logic [NC-1:0]      cfg_wr_pulse;
    logic [NS*64-1:0]   stat_regs;
    logic [63:0]        timestamp;

    lcm_regfile #(.LMID(8'd3), .NUM_CFG(NC), .NUM_STAT(NS), .DATA_W(64), .TS_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_data_wr(in_data_wr), .in_data_valid(in_data_valid),
        .in_data_valid_wr(in_data_valid_wr), .in_ready(in_ready),
        .out_data(out_data), .out_data_wr(out_data_wr), .out_data_valid(out_data_valid),
        .out_data_valid_wr(out_data_valid_wr), .out_ready(out_ready),
        .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .stat_regs(stat_regs),
        .timestamp(timestamp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    logic [63:0] cyc;
    logic [63:0] exec_ts;
    logic [63:0] m_cfg [NC];
    logic [63:0] m_stat [NS];
    logic [135:0] rq [$];

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  lmid;
        logic [7:0]  idx;
        logic [63:0] wv;
        logic        good;
        logic        rsp;
        logic [7:0]  st;
        logic [63:0] d;
    } vec_t;
    vec_t vecs [16];

    // Reference cycle count since reset release; the DUT timestamp must track it.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 64'd1;
    end

    always @(negedge clk) begin
        if (out_data_wr === 1'b1) rq.push_back({out_data_valid_wr, out_data_valid, out_data});
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = 1'b0;
                default: ;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_cfg(input string nm);
        int bad = -1;
        checks++;
        for (int i = 0; i < NC; i++) begin
            if (cfg_regs[i*64 +: 64] !== m_cfg[i] && bad < 0) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s reg%0d act=%h exp=%h", nm, bad, cfg_regs[bad*64 +: 64], m_cfg[bad]);
        end
    endtask

    task automatic set_stat(input int i, input logic [63:0] v);
        m_stat[i] = v;
        stat_regs[i*64 +: 64] = v;
    endtask

    // Leaves the bench in the cycle after the packet's last flit (EXEC if accepted).
    task automatic send(input logic [7:0] op, input logic [7:0] lmid, input logic [7:0] idx,
                        input logic [63:0] wv, input bit good, input int nb);
        logic [133:0] h;
        h = '0;
        h[133:132] = 2'b01;
        h[127:120] = op;
        h[119:112] = lmid;
        h[111:104] = idx;
        h[63:0]    = wv;
        @(posedge clk); #1;
        in_data = h; in_data_wr = 1'b1; in_data_valid = good; in_data_valid_wr = (nb == 0);
        for (int k = 1; k <= nb; k++) begin
            @(posedge clk); #1;
            in_data = {(k == nb) ? 2'b10 : 2'b11, 132'(k)};
            in_data_wr = 1'b1; in_data_valid = good; in_data_valid_wr = (k == nb);
        end
        @(posedge clk); #1;
        in_data = '0; in_data_wr = 0; in_data_valid = 0; in_data_valid_wr = 0;
        exec_ts = cyc;
    endtask

    // Address-map rules applied to the model state; returns the expected response.
    task automatic model(input logic [7:0] op, input logic [7:0] lmid, input logic [7:0] idx,
                         input logic [63:0] wv, input bit good, input logic [63:0] ts,
                         output bit rsp, output logic [7:0] st, output logic [63:0] d);
        int ii = int'(idx);
        rsp = 0; st = 8'h00; d = '0;
        if (!good || lmid != 8'd3 || !(op == 8'h01 || op == 8'h02)) return;
        if (op == 8'h01) begin
            rsp = ACK; d = wv;
            if (ii < NC) m_cfg[ii] = wv;
            else         st = 8'hFF;
        end else begin
            rsp = 1'b1;
            if (ii < NC)           d = m_cfg[ii];
            else if (ii < NC + NS) d = m_stat[ii - NC];
            else if (ii == 255)    d = ts;
            else                   st = 8'hFF;
        end
    endtask

    task automatic check_rsp(input string nm, input bit er, input logic [7:0] op,
                             input logic [7:0] idx, input logic [7:0] st, input logic [63:0] d);
        logic [135:0] eh, et;
        int lim = er ? 200 : 30;
        for (int w = 0; w < lim && rq.size() < 2; w++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk({nm, "_cnt"}, 136'(rq.size()), er ? 136'd2 : 136'd0);
        if (er && rq.size() >= 2) begin
            eh = {2'b00, 2'b01, 4'b0, op | 8'h80, 8'd3, idx, st, 96'b0};
            et = {2'b11, 2'b10, 68'b0, d};
            chk({nm, "_head"}, rq[0], eh);
            chk({nm, "_tail"}, rq[1], et);
        end
        rq.delete();
    endtask

    task automatic run_model_txn(input string nm, input logic [7:0] op, input logic [7:0] lmid,
                                 input logic [7:0] idx, input logic [63:0] wv, input bit good,
                                 input int nb);
        bit er; logic [7:0] st; logic [63:0] d;
        send(op, lmid, idx, wv, good, nb);
        model(op, lmid, idx, wv, good, exec_ts, er, st, d);
        check_rsp(nm, er, op, idx, st, d);
        chk_cfg({nm, "_cfg"});
    endtask

    initial begin
        bit er; logic [7:0] st; logic [63:0] d;
        logic [7:0] op, lm, idx;
        logic [63:0] wv;
        int r;

        vecs[0]  = '{8'h01, 8'd3, 8'd15,  64'hDEAD_BEEF_0000_0015, 1, ACK, 8'h00, 64'hDEAD_BEEF_0000_0015};
        vecs[1]  = '{8'h02, 8'd3, 8'd15,  64'h0, 1, 1'b1, 8'h00, 64'hDEAD_BEEF_0000_0015};
        vecs[2]  = '{8'h02, 8'd3, 8'd3,   64'h0, 1, 1'b1, 8'h00, 64'h1122_3344_5566_7788};
        vecs[3]  = '{8'h02, 8'd3, 8'd18,  64'h0, 1, 1'b1, 8'h00, 64'hABCD};
        vecs[4]  = '{8'h01, 8'd5, 8'd4,   64'h4444, 1, 1'b0, 8'h00, 64'h0};
        vecs[5]  = '{8'h01, 8'd3, 8'd5,   64'h5555, 0, 1'b0, 8'h00, 64'h0};
        vecs[6]  = '{8'h01, 8'd3, 8'd200, 64'h2000, 1, ACK, 8'hFF, 64'h2000};
        vecs[7]  = '{8'h02, 8'd3, 8'd4,   64'h0, 1, 1'b1, 8'h00, 64'h0};
        vecs[8]  = '{8'h02, 8'd3, 8'd5,   64'h0, 1, 1'b1, 8'h00, 64'h0};
        vecs[9]  = '{8'h02, 8'd3, 8'd200, 64'h0, 1, 1'b1, 8'hFF, 64'h0};
        vecs[10] = '{8'h02, 8'd3, 8'd40,  64'h0, 1, 1'b1, 8'hFF, 64'h0};
        vecs[11] = '{8'h01, 8'd3, 8'd18,  64'h1818, 1, ACK, 8'hFF, 64'h1818};
        vecs[12] = '{8'h03, 8'd3, 8'd3,   64'h3333, 1, 1'b0, 8'h00, 64'h0};
        vecs[13] = '{8'h02, 8'd3, 8'd31,  64'h0, 1, 1'b1, 8'h00, 64'h5100_0000_0000_000F};
        vecs[14] = '{8'h02, 8'd5, 8'd3,   64'h0, 1, 1'b0, 8'h00, 64'h0};
        vecs[15] = '{8'h02, 8'd3, 8'd3,   64'h0, 1, 1'b1, 8'h00, 64'h1122_3344_5566_7788};

        for (int i = 0; i < NC; i++) m_cfg[i] = '0;
        stat_regs = '0;
        for (int i = 0; i < NS; i++) set_stat(i, 64'h5100_0000_0000_0000 | 64'(i));
        set_stat(2, 64'hABCD);
        in_data = '0; in_data_wr = 0; in_data_valid = 0; in_data_valid_wr = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_data", 136'(out_data), 136'd0);
        chk("rst_strobes", 136'({out_data_wr, out_data_valid, out_data_valid_wr}), 136'd0);
        chk("rst_in_ready", 136'(in_ready), 136'd1);
        chk("rst_pulse", 136'(cfg_wr_pulse), 136'd0);
        chk("rst_ts", 136'(timestamp), 136'd0);
        chk_cfg("rst_cfg");
        @(posedge clk); #1;
        rst = 1'b0;

        // Timestamp read shortly after reset.
        send(8'h02, 8'd3, 8'hFF, 64'h0, 1, 0);
        check_rsp("ts_read", 1'b1, 8'h02, 8'hFF, 8'h00, exec_ts);
        @(negedge clk);
        chk("ts_track", 136'(timestamp), 136'(cyc));

        // Write latency: EXEC in T+1, register and pulse in T+2, pulse gone in T+3.
        send(8'h01, 8'd3, 8'd3, 64'h1122_3344_5566_7788, 1, 1);
        @(negedge clk);
        chk("wr_exec_pulse", 136'(cfg_wr_pulse), 136'd0);
        chk("wr_exec_reg", 136'(cfg_regs[3*64 +: 64]), 136'd0);
        @(negedge clk);
        chk("wr_pulse", 136'(cfg_wr_pulse), 136'(16'h0008));
        chk("wr_reg", 136'(cfg_regs[3*64 +: 64]), 136'(64'h1122_3344_5566_7788));
        @(negedge clk);
        chk("wr_pulse_end", 136'(cfg_wr_pulse), 136'd0);
        model(8'h01, 8'd3, 8'd3, 64'h1122_3344_5566_7788, 1, exec_ts, er, st, d);
        check_rsp("wr_ack", er, 8'h01, 8'd3, st, d);

        rdy_mode = 1;
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].lmid, vecs[i].idx, vecs[i].wv, vecs[i].good, i % 3);
            model(vecs[i].op, vecs[i].lmid, vecs[i].idx, vecs[i].wv, vecs[i].good, exec_ts,
                  er, st, d);
            check_rsp($sformatf("vec%0d", i), vecs[i].rsp, vecs[i].op, vecs[i].idx,
                      vecs[i].st, vecs[i].d);
            chk_cfg($sformatf("vec%0d_cfg", i));
        end

        // Backpressure: 10 stalled cycles, then exactly two flits.
        rdy_mode = 2;
        send(8'h02, 8'd3, 8'd18, 64'h0, 1, 2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d", k), 136'({out_data_wr, in_ready}), 136'd0);
        end
        chk("stall_q", 136'(rq.size()), 136'd0);
        rdy_mode = 0;
        check_rsp("stall_rel", 1'b1, 8'h02, 8'd18, 8'h00, 64'hABCD);

        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) set_stat($urandom_range(0, NS - 1), {$urandom, $urandom});
            r  = $urandom_range(0, 9);
            op = ($urandom_range(0, 9) == 0) ? 8'h03 : 8'(1 + $urandom_range(0, 1));
            lm = ($urandom_range(0, 7) == 0) ? 8'd7 : 8'd3;
            if (r < 4)      idx = 8'($urandom_range(0, NC - 1));
            else if (r < 7) idx = 8'($urandom_range(NC, NC + NS - 1));
            else if (r < 8) idx = 8'hFF;
            else            idx = 8'($urandom_range(NC + NS, 254));
            wv = {$urandom, $urandom};
            run_model_txn($sformatf("rnd%0d", n), op, lm, idx, wv, $urandom_range(0, 7) != 0,
                          int'($urandom_range(0, 3)));
        end

        // Reset while the tail flit is stalled.
        rdy_mode = 3;
        out_ready = 1'b0;
        send(8'h02, 8'd3, 8'd3, 64'h0, 1, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_tail_type", 136'(out_data[133:132]), 136'(2'b10));
        chk("mid_tail_wr", 136'(out_data_wr), 136'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_out", 136'(out_data), 136'd0);
        chk("arst_strobes", 136'({out_data_wr, out_data_valid, out_data_valid_wr}), 136'd0);
        chk("arst_in_ready", 136'(in_ready), 136'd1);
        chk("arst_ts", 136'(timestamp), 136'd0);
        chk("arst_pulse", 136'(cfg_wr_pulse), 136'd0);
        for (int i = 0; i < NC; i++) m_cfg[i] = '0;
        chk_cfg("arst_cfg");
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        rq.delete();
        rdy_mode = 0;
        run_model_txn("post_rd", 8'h02, 8'd3, 8'd18, 64'h0, 1, 1);
        run_model_txn("post_wr", 8'h01, 8'd3, 8'd1, 64'hCAFE_F00D_1234_5678, 1, 0);
        run_model_txn("post_rb", 8'h02, 8'd3, 8'd1, 64'h0, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcm_regfile.md
# lcm_regfile

Parametrised local control module for FAST-ANT pipelines. It decodes control packets arriving on the 134-bit DMUX packet bus and performs register writes into a configurable register file. It serves register reads from that file and from a read-only status bank, and returns 2-flit response packets on the MUX bus with ready backpressure. It also provides the module-wide timestamp.

## Interface
Parameters:
- LMID, 8'd3, module ID matched against the command header
- NUM_CFG, 16, writable config registers, 1..128
- NUM_STAT, 16, read-only status registers, 1..127
- DATA_W, 64, register width, 1..64
- TS_W, 64, timestamp width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_data  in  134  packet flit; [133:132] = 01 head / 11 body / 10 tail
- in_data_wr  in  1  flit strobe
- in_data_valid  in  1  packet good flag, sampled with in_data_valid_wr
- in_data_valid_wr  in  1  end-of-packet strobe
- in_ready  out  1  block can accept a packet
- out_data  out  134  response flit
- out_data_wr  out  1  response flit strobe
- out_data_valid  out  1  response good flag
- out_data_valid_wr  out  1  response end-of-packet strobe
- out_ready  in  1  downstream can accept a flit
- cfg_regs  out  NUM_CFG*DATA_W  flattened config registers; reg i at [i*DATA_W +: DATA_W]
- cfg_wr_pulse  out  NUM_CFG  one-cycle strobe per written register
- stat_regs  in  NUM_STAT*DATA_W  flattened status inputs
- timestamp  out  TS_W  free-running counter

## Operation
- Head flit fields:
  - [127:120] opcode: 8'h01 write, 8'h02 read
  - [119:112] target LMID
  - [111:104] register index
  - [63:0] write value, truncated to DATA_W
- Body and tail flits are ignored.
- Address map:
  - indices 0..NUM_CFG-1 are config registers
  - indices NUM_CFG..NUM_CFG+NUM_STAT-1 are status registers
  - index 8'hFF is the timestamp, truncated or zero-extended to 64 bits
  - all other indices are out of range
- FSM states:
  - IDLE: waits for a head flit with in_data_wr; latches the command; goes to RECV. A non-head flit in IDLE is discarded.
  - RECV: discards flits until in_data_valid_wr. If in_data_valid=0, or LMID mismatches, or opcode is unknown, returns to IDLE with no action. Otherwise goes to EXEC. A head flit that also carries in_data_valid_wr goes directly to this decision.
  - EXEC: one cycle.
    - A write to a config index updates the register and pulses cfg_wr_pulse[i].
    - A write to a status, timestamp or out-of-range index is ignored with status 8'hFF.
    - A read captures the data: status 8'h00 if the index is mapped, else 8'hFF with data 0.
    - A read goes to RESP_HEAD. A write goes to IDLE, or to RESP_HEAD when ack is enabled.
  - RESP_HEAD: drives the head flit while out_ready=1, then goes to RESP_TAIL.
    - [133:132]=01
    - [127:120] = opcode|8'h80
    - [119:112] = LMID
    - [111:104] = index
    - [103:96] = status
  - RESP_TAIL: drives the tail flit while out_ready=1, then returns to IDLE.
    - [133:132]=10
    - [63:0] = data (write value for an ack)
    - out_data_valid=1 and out_data_valid_wr=1
- in_ready=1 only in IDLE and RECV. Flits presented while in_ready=0 are dropped, and no state changes.
- The timestamp increments every cycle and wraps to 0 after all-ones.

## Timing
- Reset value of every output and register is 0:
  - cfg_regs, cfg_wr_pulse, timestamp
  - out_data and all out strobes
- in_ready resets to 1.
- Write latency: the tail accepted in cycle T gives EXEC in T+1; cfg_regs and cfg_wr_pulse are visible in T+2.
- Read latency: the response head flit appears in T+2 at the earliest; the tail flit follows one cycle after the head flit is accepted.
- While out_ready=0, out_data_wr is held low and the state does not advance. out_data is stable; no flit is duplicated or lost.
- Status data is sampled in EXEC, not at issue.
- Asserting rst mid-response aborts the packet immediately: outputs go to 0 and the FSM goes to IDLE.

## Configuration
- LCM_WR_ACK_EN:
  - Defined: successful and failed writes both emit a response packet with opcode 8'h81, status per EXEC, and the write value in the tail.
  - Undefined: writes are silent and go from EXEC to IDLE.
- Reads always respond.

## Test plan
- Write 0x1122334455667788 to index 3 with LMID 3 -> cfg_regs reg 3 takes the value and cfg_wr_pulse[3] pulses for one cycle, two cycles after the tail; no response without the macro, response 8'h81/status 00 with it.
- Read index NUM_CFG+2 with stat_regs reg 2 = 0xABCD -> 2-flit response: opcode 8'h82, status 00, tail [63:0]=0xABCD, out_data_valid_wr on the tail only.
- Read index 8'hFF shortly after reset -> tail data equals the timestamp captured in EXEC, a small nonzero count.
- Write with LMID 8'd5, with in_data_valid=0, and to index 200 -> the first two give no change and no response; index 200 gives no change, with status 8'hFF if acks are enabled.
- Read with out_ready held 0 for 10 cycles -> no out_data_wr and in_ready=0 throughout; after release, exactly two flits are sent.
- Assert rst during RESP_TAIL -> all outputs 0 and cfg_regs cleared; a new read afterwards completes normally.
